sort_pipe_bitonic: RTL

//  Pipelined, parametrised bitonic sorter for N = 2**LOG2N packed {key,symbol} words,

---
 rtl/sort_pipe_bitonic_pkg.sv | 66 ++++++
 rtl/sort_pipe_bitonic_cas.sv | 39 +++
 rtl/sort_pipe_bitonic.sv | 127 ++++++++++++
 3 files changed

// File: rtl/sort_pipe_bitonic_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sort_pkg
//  Purpose  : Elaboration-time helpers describing the bitonic sorting network:
//             stage count, per-stage merge/distance decomposition, the element
//             pair touched by each compare-and-swap cell and the cell's
//             direction.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package sort_pkg;

    // Total number of compare columns for 2**log2n elements.
    function automatic int sort_stages(input int log2n);
        return (log2n * (log2n + 1)) / 2;
    endfunction

    // Merge phase p of a global column index. Phase p owns p+1 columns and
    // starts at column p*(p+1)/2, independent of the element count.
    function automatic int stage_merge(input int stage);
        int p;
        p = 0;
        for (int t = 1; t < 16; t++) begin
            if (((t * (t + 1)) / 2) <= stage) begin
                p = t;
            end
        end
        return p;
    endfunction

    // log2 of the compare distance used in a column.
    function automatic int stage_dist_log(input int stage);
        int p;
        p = stage_merge(stage);
        return p - (stage - (p * (p + 1)) / 2);
    endfunction

    // Lower element index handled by cell 'index' of a column: insert a zero
    // at bit position q of the cell number.
    function automatic int cas_lo(input int stage, input int index);
        int q;
        q = stage_dist_log(stage);
        return ((index >> q) << (q + 1)) | (index & ((1 << q) - 1));
    endfunction

    // Partner (upper) element index of the cell.
    function automatic int cas_pair(input int stage, input int index);
        return cas_lo(stage, index) + (1 << stage_dist_log(stage));
    endfunction

    // Cell direction: the bitonic block the pair belongs to alternates
    // direction; the whole network is mirrored for a descending request. In
    // the last merge phase every block spans the full vector, so the final
    // direction equals desc.
    function automatic logic cas_dir(input int stage, input int index, input logic desc);
        int  p;
        int  lo;
        logic up;
        p  = stage_merge(stage);
        lo = cas_lo(stage, index);
        up = (((lo >> (p + 1)) & 1) != 0);
        return up ^ desc;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sort_pipe_bitonic_cas.sv
`default_nettype none
// ============================================================================
//  Module   : sort_cas
//  Purpose  : Combinational compare-and-swap cell on {key,symbol} words.
//             Key field compared first, symbol field breaks ties.
//  Ports    : a, b   - input words
//             dir    - 0: smaller word to lo, 1: larger word to lo
//             lo, hi - ordered outputs
//  Revision : 1.0  initial release
// ============================================================================
module sort_cas #(
    parameter int DSIZE  = 18,
    parameter int OFFSET = 8
) (
    input  logic [DSIZE-1:0] a,
    input  logic [DSIZE-1:0] b,
    input  logic             dir,
    output logic [DSIZE-1:0] lo,
    output logic [DSIZE-1:0] hi
);

    logic w_key_gt;
    logic w_key_eq;
    logic w_sym_gt;
    logic w_a_gt_b;
    logic w_swap;

    assign w_key_gt = a[DSIZE-1:OFFSET] >  b[DSIZE-1:OFFSET];
    assign w_key_eq = a[DSIZE-1:OFFSET] == b[DSIZE-1:OFFSET];
    assign w_sym_gt = a[OFFSET-1:0]     >  b[OFFSET-1:0];
    assign w_a_gt_b = w_key_gt | (w_key_eq & w_sym_gt);

    // Equal words may swap or not; the result is identical either way.
    assign w_swap = w_a_gt_b ^ dir;
    assign lo     = w_swap ? b : a;
    assign hi     = w_swap ? a : b;

endmodule
`default_nettype wire

// File: rtl/sort_pipe_bitonic.sv
`default_nettype none
// ============================================================================
//  Module   : sort_pipe_bitonic
//  Purpose  : Pipelined bitonic sorter for 2**LOG2N {key,symbol} words with a
//             per-vector direction flag and valid/ready flow control. One
//             register bank per compare column; latency = number of columns.
//  Ports    : clk, rst               - clock, asynchronous active-high reset
//             in_valid/in_ready      - input handshake
//             in_desc, in_data       - direction flag and packed input vector
//             out_valid/out_ready    - output handshake
//             out_desc, out_data     - direction flag and sorted vector
//  Revision : 1.0  initial release
// ============================================================================
module sort_pipe_bitonic
    import sort_pkg::*;
#(
    parameter int DSIZE  = 18,
    parameter int OFFSET = 8,
    parameter int LOG2N  = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        in_desc,
    input  logic [(DSIZE<<LOG2N)-1:0]   in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_desc,
    output logic [(DSIZE<<LOG2N)-1:0]   out_data
);

    localparam int N = 1 << LOG2N;
    localparam int W = N * DSIZE;
    localparam int S = sort_stages(LOG2N);

    // Stage registers k = 1..S
    logic         r_v    [1:S];
    logic         r_desc [1:S];
    logic [W-1:0] r_data [1:S];

    // Inputs and outputs of compare column c = 0..S-1
    logic         w_src_v    [0:S-1];
    logic         w_src_desc [0:S-1];
    logic [W-1:0] w_src_data [0:S-1];
    logic [W-1:0] w_cas_data [0:S-1];

    logic [S:1]   w_rdy;
    logic         w_acc;

    // Column 0 reads the input port, column c reads stage register c.
    always_comb begin
        w_src_v[0]    = in_valid;
        w_src_desc[0] = in_desc;
        w_src_data[0] = in_data;
        for (int c = 1; c < S; c++) begin
            w_src_v[c]    = r_v[c];
            w_src_desc[c] = r_desc[c];
            w_src_data[c] = r_data[c];
        end
    end

    genvar gc, gj;
    generate
        for (gc = 0; gc < S; gc++) begin : g_stage
            for (gj = 0; gj < N / 2; gj++) begin : g_cell
                localparam int   LO   = cas_lo(gc, gj);
                localparam int   HI   = cas_pair(gc, gj);
                localparam logic DIR0 = cas_dir(gc, gj, 1'b0);

                logic w_dir;
                assign w_dir = DIR0 ^ w_src_desc[gc];

                sort_cas #(
                    .DSIZE  (DSIZE),
                    .OFFSET (OFFSET)
                ) u_cas (
                    .a   (w_src_data[gc][LO*DSIZE +: DSIZE]),
                    .b   (w_src_data[gc][HI*DSIZE +: DSIZE]),
                    .dir (w_dir),
                    .lo  (w_cas_data[gc][LO*DSIZE +: DSIZE]),
                    .hi  (w_cas_data[gc][HI*DSIZE +: DSIZE])
                );
            end
        end
    endgenerate

    // A stage may load when it is empty or when some later stage is empty
    // or the sink is taking the oldest vector, i.e. rdy[k] = !v[k] | rdy[k+1]
    // unrolled from the output end.
    always_comb begin
        w_rdy = '0;
        w_acc = out_ready;
        for (int k = S; k >= 1; k--) begin
            w_acc    = w_acc | !r_v[k];
            w_rdy[k] = w_acc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 1; k <= S; k++) begin
                r_v[k]    <= 1'b0;
                r_desc[k] <= 1'b0;
                r_data[k] <= '0;
            end
        end else begin
            for (int k = 1; k <= S; k++) begin
                if (w_rdy[k]) begin
                    r_v[k] <= w_src_v[k-1];
                    // Payload only moves with a valid vector; bubbles leave it.
                    if (w_src_v[k-1]) begin
                        r_desc[k] <= w_src_desc[k-1];
                        r_data[k] <= w_cas_data[k-1];
                    end
                end
            end
        end
    end

    assign in_ready  = w_rdy[1];
    assign out_valid = r_v[S];
    assign out_desc  = r_desc[S];
    assign out_data  = r_data[S];

endmodule
`default_nettype wire
